// File: rtl/otp_stream_cipher.sv
// One-time-pad XOR stream cipher: a KEY_DEPTH-word pad consumed one word per encrypted beat,
// with a single-register valid/ready output stage and a per-beat bypass.
module otp_stream_cipher #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    KEY_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_KEY = 16'h3327,
  parameter bit                    WRAP_EN     = 1'b0,
  localparam int                   AW          = $clog2(KEY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_wr_en,
  input  logic [AW-1:0]         key_wr_addr,
  input  logic [DATA_WIDTH-1:0] key_wr_data,
  input  logic                  key_rewind,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_bypass,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [AW-1:0]         key_index,
  output logic                  key_exhausted
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(KEY_DEPTH - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pad_q [KEY_DEPTH];
  logic [DATA_WIDTH-1:0] pad_d [KEY_DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]         key_index_q, key_index_d;
  logic                  exhausted_q, exhausted_d;
  logic                  accept, consume;

  assign out_valid     = (state_q == FULL);
  assign out_data      = out_data_q;
  assign key_index     = key_index_q;
  assign key_exhausted = exhausted_q;

  // Exhaustion only blocks beats that would need a pad word.
  assign in_ready = reset_n && (!out_valid || out_ready) && (in_bypass || !exhausted_q);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    key_index_d = key_index_q;
    exhausted_d = exhausted_q;
    pad_d       = pad_q;

    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (consume && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase

    // Encryption reads the pad before this edge's write lands.
    if (accept) begin
      out_data_d = in_bypass ? in_data : (in_data ^ pad_q[key_index_q]);
    end

    if (key_rewind) begin
      key_index_d = '0;
      exhausted_d = 1'b0;
    end else if (accept && !in_bypass) begin
      if (key_index_q == LAST_IDX) begin
        if (WRAP_EN) key_index_d = '0;
        else         exhausted_d = 1'b1;
      end else begin
        key_index_d = key_index_q + AW'(1);
      end
    end

    if (key_wr_en && (32'(key_wr_addr) < KEY_DEPTH)) begin
      pad_d[key_wr_addr] = key_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      out_data_q  <= '0;
      key_index_q <= '0;
      exhausted_q <= 1'b0;
      for (int i = 0; i < KEY_DEPTH; i++) pad_q[i] <= DEFAULT_KEY;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      key_index_q <= key_index_d;
      exhausted_q <= exhausted_d;
      pad_q       <= pad_d;
    end
  end

endmodule
